// File: rtl/uart_rx_core.sv
// UART receiver core: 2-flop synchroniser, 3-sample majority vote, 8N1 deserialiser with valid/ready hold.
// Optional parity bit (even/odd via PARITY_ODD) and parity_err output when UART_RX_PARITY_EN is defined.
module uart_rx_core #(
   parameter int SAMPLE_RATE = 24,
   parameter int MID_TICK    = SAMPLE_RATE / 2
`ifdef UART_RX_PARITY_EN
   ,
   parameter int PARITY_ODD  = 0
`endif
) (
   input  logic       clk,
   input  logic       rstb,
   input  logic       rx_clk_en,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       rx_overrun,
   output logic       rx_busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_err
`endif
);

   localparam int TW = $clog2(SAMPLE_RATE);

   // tcnt holds the index of the most recent tick, so a tick with tcnt_q == k is tick k+1.
   localparam logic [TW-1:0] LAST_T   = TW'(SAMPLE_RATE - 1);
   localparam logic [TW-1:0] CAP_A_T  = TW'(MID_TICK - 2);
   localparam logic [TW-1:0] CAP_B_T  = TW'(MID_TICK - 1);
   localparam logic [TW-1:0] DECIDE_T = TW'(MID_TICK);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
   } state_t;
`endif

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   state_t          state_q, state_d;
   logic            sync1_q, sync2_q;
   logic            rxs;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [2:0]      bcnt_q, bcnt_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            va_q, va_d;
   logic            vb_q, vb_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            overrun_q, overrun_d;
   logic            decide;
   logic            vote;
   logic            byte_ok;
`ifdef UART_RX_PARITY_EN
   logic            par_bit_q, par_bit_d;
   logic            parity_err_q, parity_err_d;

   function automatic logic parity_good(input logic [7:0] d, input logic p);
      return ((^d) ^ p) == PARITY_ODD[0];
   endfunction
`endif

   assign rxs    = sync2_q;
   assign decide = rx_clk_en && (tcnt_q == DECIDE_T);
   assign vote   = maj3(va_q, vb_q, rxs);

`ifdef UART_RX_PARITY_EN
   assign byte_ok = parity_good(shreg_q, par_bit_q);
`else
   assign byte_ok = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      tcnt_d      = tcnt_q;
      bcnt_d      = bcnt_q;
      shreg_d     = shreg_q;
      va_d        = va_q;
      vb_d        = vb_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = (rx_valid_q && rx_ready) ? 1'b0 : rx_valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_d    = par_bit_q;
      parity_err_d = 1'b0;
`endif

      if (rx_clk_en) begin
         tcnt_d = (tcnt_q == LAST_T) ? '0 : tcnt_q + 1'b1;
         if (tcnt_q == CAP_A_T) va_d = rxs;
         if (tcnt_q == CAP_B_T) vb_d = rxs;
      end

      case (state_q)
         S_IDLE: begin
            if (rx_clk_en && !rxs) begin
               state_d = S_START;
               tcnt_d  = '0;
            end
         end
         S_START: begin
            if (decide) begin
               if (vote) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  bcnt_d  = 3'd0;
               end
            end
         end
         S_DATA: begin
            if (decide) begin
               shreg_d = {vote, shreg_q[7:1]};
               bcnt_d  = bcnt_q + 3'd1;
               if (bcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (decide) begin
               par_bit_d = vote;
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (decide) begin
`ifdef UART_RX_PARITY_EN
               parity_err_d = !byte_ok;
`endif
               if (vote) begin
                  if (byte_ok) begin
                     // A consumer read in the same cycle frees the holding register for this byte.
                     if (!rx_valid_q || rx_ready) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                     end else begin
                        overrun_d = 1'b1;
                     end
                  end
                  state_d = S_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_WAIT_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (rx_clk_en && rxs) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q     <= S_IDLE;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         tcnt_q      <= '0;
         bcnt_q      <= 3'd0;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sync1_q     <= rxd;
         sync2_q     <= sync1_q;
         tcnt_q      <= tcnt_d;
         bcnt_q      <= bcnt_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   // Sample and shift storage is only meaningful once a frame is under way.
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_d;
`endif
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign frame_err  = frame_err_q;
   assign rx_overrun = overrun_q;
   assign rx_busy    = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: 8N1 reception, glitch rejection, framing, overrun, reset mid-frame.
// Parity cases are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_core;

   localparam int SR      = 24;
   localparam int TDIV    = 4;
   localparam int BIT_CLK = SR * TDIV;

   logic       clk       = 1'b0;
   logic       rstb      = 1'b0;
   logic       rx_clk_en = 1'b0;
   logic       rxd       = 1'b1;
   logic       rx_ready  = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       rx_overrun;
   logic       rx_busy;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
   logic       bad_par = 1'b0;
   int         pe_cnt  = 0;
   int         pe0;
`endif

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int tdiv   = 0;
   int fe0, ov0;

   uart_rx_core #(.SAMPLE_RATE(SR)) dut (
      .clk        (clk),
      .rstb       (rstb),
      .rx_clk_en  (rx_clk_en),
      .rxd        (rxd),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .rx_overrun (rx_overrun),
      .rx_busy    (rx_busy)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      tdiv      <= (tdiv == TDIV - 1) ? 0 : tdiv + 1;
      rx_clk_en <= (tdiv == TDIV - 1);
   end

   // Pulse-width counters: each one-clk pulse adds exactly one.
   always @(negedge clk) begin
      if (frame_err)  fe_cnt <= fe_cnt + 1;
      if (rx_overrun) ov_cnt <= ov_cnt + 1;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_cnt <= pe_cnt + 1;
`endif
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      wait_clk(BIT_CLK);
   endtask

   task automatic send_bits(input logic [7:0] d);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ bad_par);
`endif
   endtask

   task automatic snap();
      fe0 = fe_cnt;
      ov0 = ov_cnt;
`ifdef UART_RX_PARITY_EN
      pe0 = pe_cnt;
`endif
   endtask

   task automatic read_pulse();
      rx_ready = 1'b1;
      wait_clk(1);
      rx_ready = 1'b0;
   endtask

   initial begin
      wait_clk(5);
      chk("rst_data",    rx_data,          8'h00);
      chk("rst_valid",   8'(rx_valid),     8'd0);
      chk("rst_ferr",    8'(frame_err),    8'd0);
      chk("rst_overrun", 8'(rx_overrun),   8'd0);
      chk("rst_busy",    8'(rx_busy),      8'd0);
      rstb = 1'b1;
      wait_clk(20);

      // 0x55, nothing read
      snap();
      send_bits(8'h55);
      chk("t1_valid_early", 8'(rx_valid), 8'd0);
      chk("t1_busy_mid",    8'(rx_busy),  8'd1);
      send_bit(1'b1);
      chk("t1_valid", 8'(rx_valid),       8'd1);
      chk("t1_data",  rx_data,            8'h55);
      chk("t1_ferr",  8'(fe_cnt - fe0),   8'd0);
      chk("t1_busy",  8'(rx_busy),        8'd0);
      read_pulse();
      chk("t1_cleared", 8'(rx_valid), 8'd0);

      // start glitch of 8 ticks
      snap();
      rxd = 1'b0;
      wait_clk(20);
      chk("gl_busy_start", 8'(rx_busy), 8'd1);
      wait_clk(8 * TDIV - 20);
      rxd = 1'b1;
      wait_clk(100);
      chk("gl_busy",  8'(rx_busy),      8'd0);
      chk("gl_valid", 8'(rx_valid),     8'd0);
      chk("gl_ferr",  8'(fe_cnt - fe0), 8'd0);

      // 0xA3 with stop=0, then line held low
      wait_clk(50);
      snap();
      send_bits(8'hA3);
      send_bit(1'b0);
      wait_clk(100 * TDIV);
      chk("fe_pulse", 8'(fe_cnt - fe0), 8'd1);
      chk("fe_valid", 8'(rx_valid),     8'd0);
      chk("fe_wait",  8'(rx_busy),      8'd1);
      rxd = 1'b1;
      wait_clk(40);
      chk("fe_idle",  8'(rx_busy),      8'd0);

      // 0x12 then 0x34 back-to-back, nothing read
      wait_clk(50);
      snap();
      send_bits(8'h12);
      send_bit(1'b1);
      send_bits(8'h34);
      send_bit(1'b1);
      wait_clk(20);
      chk("ov_valid", 8'(rx_valid),     8'd1);
      chk("ov_data",  rx_data,          8'h12);
      chk("ov_pulse", 8'(ov_cnt - ov0), 8'd1);
      chk("ov_ferr",  8'(fe_cnt - fe0), 8'd0);
      read_pulse();
      chk("ov_cleared", 8'(rx_valid), 8'd0);

      // reset during data bit 4 of 0xF0
      wait_clk(50);
      snap();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      rxd = 1'b1;
      wait_clk(BIT_CLK / 2);
      rstb = 1'b0;
      wait_clk(3);
      chk("mr_busy",  8'(rx_busy),  8'd0);
      chk("mr_valid", 8'(rx_valid), 8'd0);
      chk("mr_data",  rx_data,      8'h00);
      wait_clk(2);
      rstb = 1'b1;
      wait_clk(2 * BIT_CLK);
      send_bits(8'h0F);
      send_bit(1'b1);
      wait_clk(10);
      chk("mr_new_data",  rx_data,          8'h0F);
      chk("mr_new_valid", 8'(rx_valid),     8'd1);
      chk("mr_ferr",      8'(fe_cnt - fe0), 8'd0);
      chk("mr_overrun",   8'(ov_cnt - ov0), 8'd0);

`ifdef UART_RX_PARITY_EN
      read_pulse();
      chk("pa_cleared", 8'(rx_valid), 8'd0);
      snap();
      bad_par = 1'b1;
      send_bits(8'h07);
      send_bit(1'b1);
      wait_clk(10);
      chk("pa_bad_pulse", 8'(pe_cnt - pe0), 8'd1);
      chk("pa_bad_valid", 8'(rx_valid),     8'd0);
      chk("pa_bad_ov",    8'(ov_cnt - ov0), 8'd0);
      bad_par = 1'b0;
      send_bits(8'h07);
      send_bit(1'b1);
      wait_clk(10);
      chk("pa_good_data",  rx_data,          8'h07);
      chk("pa_good_valid", 8'(rx_valid),     8'd1);
      chk("pa_good_pulse", 8'(pe_cnt - pe0), 8'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
